// File: rtl/systolic_pkg.sv
// Shared types and size defaults for the systolic feed scheduler slice.
package systolic_pkg;

   localparam int unsigned SYSTOLIC_SIZE_DEF = 16;
   localparam int unsigned FIFO_DEPTH_DEF    = 256;

   typedef enum logic [2:0] {
      IDLE,
      FLUSH,
      FEED,
      SHIFT,
      DRAIN
   } sched_state_t;

   typedef enum logic {
      PHASE_A,
      PHASE_B
   } phase_t;

endpackage

// File: rtl/feed_phase_mux.sv
// A/B phase alternation for the shared buffer port: read-address mux and
// one-cycle-delayed valid_a/valid_b that line up with returning buffer data.
module feed_phase_mux
   import systolic_pkg::*;
#(
   parameter int unsigned AW = 8
)
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          feed,
   input  logic          phase_clr,
   input  logic          issue_en_a,
   input  logic          issue_en_b,
   input  logic [AW-1:0] fifo_addr_a,
   input  logic [AW-1:0] fifo_addr_b,
   output logic [AW-1:0] fifo_rd_addr,
   output logic          valid_a,
   output logic          valid_b
);

   phase_t phase;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase   <= PHASE_A;
         valid_a <= 1'b0;
         valid_b <= 1'b0;
      end else begin
         if (phase_clr)
            phase <= PHASE_A;
         else if (feed)
            phase <= (phase == PHASE_A) ? PHASE_B : PHASE_A;
         // A finished side keeps its slot in the alternation but issues no valid
         valid_a <= feed && (phase == PHASE_A) && issue_en_a;
         valid_b <= feed && (phase == PHASE_B) && issue_en_b;
      end
   end

   always_comb begin
      fifo_rd_addr = '0;
      if (feed)
         fifo_rd_addr = (phase == PHASE_A) ? fifo_addr_a : fifo_addr_b;
   end

endmodule

// File: rtl/systolic_feed_scheduler.sv
// Job sequencer feeding A/B wavefronts into an NxN systolic array.
// Optional FEED_SCHED_PERF_EN adds a perf_cycles busy-cycle counter output.
module systolic_feed_scheduler
   import systolic_pkg::*;
#(
   parameter  int unsigned DATA_WIDTH    = 32,
   parameter  int unsigned FIFO_DEPTH    = FIFO_DEPTH_DEF,
   parameter  int unsigned SYSTOLIC_SIZE = SYSTOLIC_SIZE_DEF,
   parameter  int unsigned DRAIN_CYCLES  = 2*SYSTOLIC_SIZE-1,
   localparam int unsigned AW            = $clog2(FIFO_DEPTH),
   localparam int unsigned WW            = $clog2(SYSTOLIC_SIZE)+1
)
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          abort,
   input  logic [AW-1:0] base_addr_a_in,
   input  logic [AW-1:0] base_addr_b_in,
   input  logic [WW-1:0] matrix_width_in,
   input  logic [AW-1:0] fifo_addr_a,
   input  logic [AW-1:0] fifo_addr_b,
   input  logic          completed_a,
   input  logic          completed_b,
   output logic [AW-1:0] fifo_rd_addr,
   output logic          ext_rst_flush,
   output logic          ext_enable,
   output logic          valid_a,
   output logic          valid_b,
   output logic [AW-1:0] base_addr_a,
   output logic [AW-1:0] base_addr_b,
   output logic [WW-1:0] matrix_width,
   output logic          array_shift,
   output logic          busy,
   output logic          done,
   output logic          cfg_err
`ifdef FEED_SCHED_PERF_EN
   ,
   output logic [31:0]   perf_cycles
`endif
);

   localparam int unsigned   CW         = WW + 1;
   localparam int unsigned   DW         = $clog2(DRAIN_CYCLES + 1);
   localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);
   localparam logic [WW-1:0] N_MAX      = WW'(SYSTOLIC_SIZE);

   sched_state_t  state, state_nxt;
   logic          aborting;
   logic          done_a, done_b, done_a_nxt, done_b_nxt;
   logic [CW-1:0] wf_cnt, wf_inc, wf_target;
   logic [DW-1:0] drain_cnt;
   logic          cfg_ok, accept;

   assign cfg_ok     = (matrix_width_in != '0) && (matrix_width_in <= N_MAX);
   assign accept     = (state == IDLE) && start && !abort && cfg_ok;
   assign wf_inc     = (wf_cnt == '1) ? wf_cnt : wf_cnt + 1'b1;
   assign wf_target  = {matrix_width, 1'b0} - 1'b1;
   assign done_a_nxt = done_a | (completed_a & valid_a);
   assign done_b_nxt = done_b | (completed_b & valid_b);
   assign busy       = (state != IDLE);

   always_comb begin
      state_nxt     = state;
      ext_rst_flush = 1'b0;
      ext_enable    = 1'b0;
      array_shift   = 1'b0;
      done          = 1'b0;
      cfg_err       = 1'b0;
      case (state)
         IDLE: begin
            if (start && !abort) begin
               if (cfg_ok) state_nxt = FLUSH;
               else        cfg_err   = 1'b1;
            end
         end
         FLUSH: begin
            ext_rst_flush = 1'b1;
            state_nxt     = aborting ? IDLE : FEED;
         end
         FEED: begin
            ext_enable = 1'b1;
            if (done_a_nxt && done_b_nxt) state_nxt = SHIFT;
         end
         SHIFT: begin
            array_shift = 1'b1;
            state_nxt   = (wf_inc >= wf_target) ? DRAIN : FEED;
         end
         DRAIN: begin
            if (drain_cnt >= DRAIN_LAST) begin
               done      = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
      // Abort reuses FLUSH as a one-cycle extractor cleanup before IDLE
      if (abort && state != IDLE) begin
         state_nxt = FLUSH;
         done      = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         aborting     <= 1'b0;
         done_a       <= 1'b0;
         done_b       <= 1'b0;
         wf_cnt       <= '0;
         drain_cnt    <= '0;
         base_addr_a  <= '0;
         base_addr_b  <= '0;
         matrix_width <= '0;
      end else begin
         state <= state_nxt;
         if (abort && state != IDLE) aborting <= 1'b1;
         else if (state == FLUSH)    aborting <= 1'b0;
         if (accept) begin
            base_addr_a  <= base_addr_a_in;
            base_addr_b  <= base_addr_b_in;
            matrix_width <= matrix_width_in;
         end
         if (state == FLUSH || state == SHIFT) begin
            done_a <= 1'b0;
            done_b <= 1'b0;
         end else begin
            done_a <= done_a_nxt;
            done_b <= done_b_nxt;
         end
         if (state == FLUSH)      wf_cnt <= '0;
         else if (state == SHIFT) wf_cnt <= wf_inc;
         if (state != DRAIN)        drain_cnt <= '0;
         else if (drain_cnt != '1)  drain_cnt <= drain_cnt + 1'b1;
      end
   end

   feed_phase_mux #(.AW(AW)) u_phase_mux (
      .clk          (clk),
      .rst_n        (rst_n),
      .feed         (state == FEED),
      .phase_clr    (state == FLUSH || state == SHIFT),
      .issue_en_a   (!done_a && !abort),
      .issue_en_b   (!done_b && !abort),
      .fifo_addr_a  (fifo_addr_a),
      .fifo_addr_b  (fifo_addr_b),
      .fifo_rd_addr (fifo_rd_addr),
      .valid_a      (valid_a),
      .valid_b      (valid_b)
   );

`ifdef FEED_SCHED_PERF_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)               perf_cycles <= '0;
      else if (state == FLUSH)  perf_cycles <= '0;
      else if (state != IDLE)   perf_cycles <= perf_cycles + 32'd1;
   end
`endif

endmodule

// File: tb/tb_systolic_feed_scheduler.sv
// Directed self-checking bench for systolic_feed_scheduler (N up to 16, 31 drain cycles).
module tb_systolic_feed_scheduler;

   logic       clk, rst_n, start, abort, completed_a, completed_b;
   logic [7:0] base_addr_a_in, base_addr_b_in, fifo_addr_a, fifo_addr_b;
   logic [4:0] matrix_width_in;
   logic [7:0] fifo_rd_addr, base_addr_a, base_addr_b;
   logic [4:0] matrix_width;
   logic       ext_rst_flush, ext_enable, valid_a, valid_b, array_shift, busy, done, cfg_err;
`ifdef FEED_SCHED_PERF_EN
   logic [31:0] perf_cycles;
`endif

   int errors = 0;
   int checks = 0;

   systolic_feed_scheduler #(
      .DATA_WIDTH    (32),
      .FIFO_DEPTH    (256),
      .SYSTOLIC_SIZE (16),
      .DRAIN_CYCLES  (31)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .start           (start),
      .abort           (abort),
      .base_addr_a_in  (base_addr_a_in),
      .base_addr_b_in  (base_addr_b_in),
      .matrix_width_in (matrix_width_in),
      .fifo_addr_a     (fifo_addr_a),
      .fifo_addr_b     (fifo_addr_b),
      .completed_a     (completed_a),
      .completed_b     (completed_b),
      .fifo_rd_addr    (fifo_rd_addr),
      .ext_rst_flush   (ext_rst_flush),
      .ext_enable      (ext_enable),
      .valid_a         (valid_a),
      .valid_b         (valid_b),
      .base_addr_a     (base_addr_a),
      .base_addr_b     (base_addr_b),
      .matrix_width    (matrix_width),
      .array_shift     (array_shift),
      .busy            (busy),
      .done            (done),
      .cfg_err         (cfg_err)
`ifdef FEED_SCHED_PERF_EN
      ,
      .perf_cycles     (perf_cycles)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_busy"},      32'(busy), 0);
      chk({tag, "_done"},      32'(done), 0);
      chk({tag, "_rd_addr"},   32'(fifo_rd_addr), 0);
      chk({tag, "_base_a"},    32'(base_addr_a), 0);
      chk({tag, "_base_b"},    32'(base_addr_b), 0);
      chk({tag, "_width"},     32'(matrix_width), 0);
      chk({tag, "_valid_a"},   32'(valid_a), 0);
      chk({tag, "_valid_b"},   32'(valid_b), 0);
      chk({tag, "_flush"},     32'(ext_rst_flush), 0);
      chk({tag, "_enable"},    32'(ext_enable), 0);
      chk({tag, "_shift"},     32'(array_shift), 0);
      chk({tag, "_cfg_err"},   32'(cfg_err), 0);
   endtask

   // Runs one job with an extractor stub that completes wavefront k after
   // min(k+1, 2N-1-k) valids on each side. rst_at>0 resets that many cycles into DRAIN.
   task automatic run_job(input int n, input logic [7:0] ba, input logic [7:0] bb, input int rst_at,
                          output int shifts, output int gap, output int dones, output int overlap);
      int k, ca, cb, len, last_shift;
      k = 0; ca = 0; cb = 0; shifts = 0; gap = -1; dones = 0; overlap = 0; last_shift = 0;
      start = 1'b1; matrix_width_in = 5'(n); base_addr_a_in = ba; base_addr_b_in = bb;
      tick();
      start = 1'b0;
      for (int c = 1; c < 800; c++) begin
         len = (k + 1 < 2*n - 1 - k) ? k + 1 : 2*n - 1 - k;
         completed_a = valid_a && (ca + 1 >= len);
         completed_b = valid_b && (cb + 1 >= len);
         if (valid_a) ca++;
         if (valid_b) cb++;
         if (valid_a && valid_b) overlap++;
         if (array_shift) begin
            shifts++; last_shift = c; k++; ca = 0; cb = 0;
         end
         if (done) begin
            dones++; gap = c - last_shift;
         end
         if (rst_at > 0 && shifts == 2*n - 1 && c - last_shift == rst_at) begin
            #2 rst_n = 1'b0;
            #1 chk_all_zero("rst_mid_drain");
            completed_a = 1'b0; completed_b = 1'b0;
            repeat (3) begin
               tick();
               if (done) dones++;
            end
            #2 rst_n = 1'b1;
            break;
         end
         if (!busy) break;
         tick();
      end
      completed_a = 1'b0; completed_b = 1'b0;
      tick();
   endtask

   typedef struct {
      logic       start;
      logic       abort;
      logic [4:0] n;
      logic       exp_cfg_err;
      logic       exp_busy;
   } cfg_vec_t;

   cfg_vec_t vecs[8];

   initial begin
      int shifts, gap, dones, overlap, nshift, ndone;

      vecs[0] = '{1'b1, 1'b0, 5'd0,  1'b1, 1'b0};
      vecs[1] = '{1'b1, 1'b0, 5'd17, 1'b1, 1'b0};
      vecs[2] = '{1'b0, 1'b0, 5'd17, 1'b0, 1'b0};
      vecs[3] = '{1'b1, 1'b1, 5'd4,  1'b0, 1'b0};
      vecs[4] = '{1'b1, 1'b1, 5'd0,  1'b0, 1'b0};
      vecs[5] = '{1'b1, 1'b0, 5'd31, 1'b1, 1'b0};
      vecs[6] = '{1'b1, 1'b0, 5'd16, 1'b0, 1'b1};
      vecs[7] = '{1'b1, 1'b0, 5'd1,  1'b0, 1'b1};

      rst_n = 1'b0; start = 1'b0; abort = 1'b0; completed_a = 1'b0; completed_b = 1'b0;
      base_addr_a_in = 8'd7; base_addr_b_in = 8'd9; matrix_width_in = 5'd4;
      fifo_addr_a = 8'd5; fifo_addr_b = 8'd20;
      #2 chk_all_zero("reset");
      tick(); tick();
      rst_n = 1'b1;
      tick();
      chk("idle_after_reset_busy", 32'(busy), 0);

      // IDLE configuration vectors
      for (int i = 0; i < 8; i++) begin
         start = vecs[i].start; abort = vecs[i].abort; matrix_width_in = vecs[i].n;
         base_addr_a_in = 8'(i + 1); base_addr_b_in = 8'(i + 40);
         #1 chk($sformatf("cfg_err_v%0d", i), 32'(cfg_err), 32'(vecs[i].exp_cfg_err));
         tick();
         start = 1'b0; abort = 1'b0;
         chk($sformatf("busy_v%0d", i), 32'(busy), 32'(vecs[i].exp_busy));
         chk($sformatf("flush_v%0d", i), 32'(ext_rst_flush), 32'(vecs[i].exp_busy));
         if (vecs[i].exp_busy) begin
            chk($sformatf("width_v%0d", i), 32'(matrix_width), 32'(vecs[i].n));
            chk($sformatf("base_a_v%0d", i), 32'(base_addr_a), 32'(i + 1));
            tick();
            chk($sformatf("enable_v%0d", i), 32'(ext_enable), 1);
            abort = 1'b1;
            tick();
            abort = 1'b0;
            chk($sformatf("abort_flush_v%0d", i), 32'(ext_rst_flush), 1);
            tick();
            chk($sformatf("abort_idle_v%0d", i), 32'(busy), 0);
         end
      end

      // Alternation, valid timing, early completed_a, single shift
      matrix_width_in = 5'd4; base_addr_a_in = 8'd0; base_addr_b_in = 8'd16;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      nshift = 0;
      for (int i = 0; i <= 18; i++) begin
         completed_a = (i == 9);
         completed_b = (i == 15 || i == 16);
         #1;
         if (array_shift) nshift++;
         if (i <= 16) begin
            chk($sformatf("rd_addr_c%0d", i), 32'(fifo_rd_addr), (i % 2 == 0) ? 5 : 20);
            chk($sformatf("valid_a_c%0d", i), 32'(valid_a), 32'((i % 2 == 1) && i <= 9));
            chk($sformatf("valid_b_c%0d", i), 32'(valid_b), 32'((i % 2 == 0) && i > 0));
         end else if (i == 17) begin
            chk("shift_pulse", 32'(array_shift), 1);
            chk("shift_valid_a", 32'(valid_a), 0);
            chk("shift_valid_b", 32'(valid_b), 0);
            chk("shift_enable", 32'(ext_enable), 0);
         end else begin
            chk("post_shift_rd_addr", 32'(fifo_rd_addr), 5);
            chk("post_shift_no_shift", 32'(array_shift), 0);
         end
         tick();
      end
      completed_a = 1'b0; completed_b = 1'b0;
      chk("single_shift_count", 32'(nshift), 1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      tick();
      chk("feed_seq_end_idle", 32'(busy), 0);

      // Abort in the third FEED cycle
      matrix_width_in = 5'd3;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick(); tick();
      abort = 1'b1;
      #1 chk("abort_c3_enable", 32'(ext_enable), 1);
      tick();
      abort = 1'b0;
      chk("abort_flush", 32'(ext_rst_flush), 1);
      chk("abort_flush_enable", 32'(ext_enable), 0);
      chk("abort_flush_busy", 32'(busy), 1);
      tick();
      chk("abort_idle_busy", 32'(busy), 0);
      chk("abort_idle_flush", 32'(ext_rst_flush), 0);
      ndone = 0;
      for (int i = 0; i < 40; i++) begin
         if (done) ndone++;
         tick();
      end
      chk("abort_no_done", 32'(ndone), 0);

      // Full N=4 job
      run_job(4, 8'd0, 8'd16, 0, shifts, gap, dones, overlap);
      chk("n4_shifts", 32'(shifts), 7);
      chk("n4_done_gap", 32'(gap), 31);
      chk("n4_done_count", 32'(dones), 1);
      chk("n4_valid_overlap", 32'(overlap), 0);
      chk("n4_idle", 32'(busy), 0);

      // Reset mid-DRAIN, then N=2 job
      run_job(4, 8'd3, 8'd16, 5, shifts, gap, dones, overlap);
      chk("rst_job_no_done", 32'(dones), 0);
      chk("rst_job_idle", 32'(busy), 0);
      run_job(2, 8'd0, 8'd16, 0, shifts, gap, dones, overlap);
      chk("n2_shifts", 32'(shifts), 3);
      chk("n2_done_gap", 32'(gap), 31);
      chk("n2_done_count", 32'(dones), 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/systolic_feed_scheduler.md
SYSTOLIC_FEED_SCHEDULER -- requirements
Module: systolic_feed_scheduler

Interface
REQ-001 Parameter DATA_WIDTH, default 32: element width.
REQ-002 Parameter FIFO_DEPTH, default 256: buffer words; AW = $clog2(FIFO_DEPTH).
REQ-003 Parameter SYSTOLIC_SIZE, default 16: array edge length; WW = $clog2(SYSTOLIC_SIZE)+1.
REQ-004 Parameter DRAIN_CYCLES, default 2*SYSTOLIC_SIZE-1: post-feed array drain time.
REQ-005 Port list (name, direction, width, meaning):
- clk, in, 1: single clock.
- rst_n, in, 1: asynchronous active-low reset.
- start, in, 1: begin job (IDLE only).
- abort, in, 1: cancel job.
- base_addr_a_in / base_addr_b_in, in, AW: matrix bases.
- matrix_width_in, in, WW: N.
- fifo_addr_a / fifo_addr_b, in, AW: extractor requests.
- completed_a / completed_b, in, 1: extractor wavefront ends.
- fifo_rd_addr, out, AW: shared buffer read address (data returns 1 cycle later).
- ext_rst_flush, out, 1: extractor flush.
- ext_enable, out, 1: extractor enable.
- valid_a / valid_b, out, 1: buffer data is for A / B.
- base_addr_a / base_addr_b, out, AW: latched bases.
- matrix_width, out, WW: latched N.
- array_shift, out, 1: advance array one wavefront.
- busy, out, 1: job active.
- done, out, 1: one-cycle job-complete pulse.
- cfg_err, out, 1: one-cycle illegal-config pulse.

Function
REQ-006 FSM states IDLE, FLUSH, FEED, SHIFT, DRAIN.
REQ-007 IDLE: start with 1<=matrix_width_in<=SYSTOLIC_SIZE -> FLUSH, latch bases and N; out-of-range N -> cfg_err pulse, stay IDLE.
REQ-008 FLUSH: exactly one cycle, ext_rst_flush=1, ext_enable=0, wavefront count cleared, phase=A; then FEED.
REQ-009 FEED: ext_enable=1; phase toggles every cycle; fifo_rd_addr = fifo_addr_a in A phase, fifo_addr_b in B phase.
REQ-010 valid_a (valid_b) asserts in the cycle after an A (B) phase issue, never both in the same cycle.
REQ-011 Sticky flags done_a/done_b set when completed_x is high while valid_x is high.
REQ-012 Once done_x is set, its later phase slots issue no valid_x; alternation continues unchanged.
REQ-013 When both flags are set -> SHIFT: array_shift=1 for one cycle, no valid issued, flags cleared, wavefront count +1.
REQ-014 Wavefront count reaching 2N-1 -> DRAIN; otherwise -> FEED with phase=A.
REQ-015 DRAIN: counter runs DRAIN_CYCLES cycles, then done=1 for one cycle, -> IDLE.
REQ-016 abort in any non-IDLE state -> FLUSH for one cycle, then IDLE; no done.
REQ-017 abort and start in the same cycle in IDLE: abort wins.
REQ-018 start outside IDLE is ignored.
REQ-019 busy=1 in every state except IDLE.
REQ-020 Wavefront and drain counters saturate; they never wrap.

Reset
REQ-021 rst_n low -> IDLE, phase=A, all counters/flags 0, all outputs 0, including fifo_rd_addr, bases and matrix_width.
REQ-022 Reset mid-job discards the job; no done is emitted.

Configuration
REQ-023 With FEED_SCHED_PERF_EN defined: add output perf_cycles (32 bits), counting busy cycles of the last job, cleared on FLUSH and held after done.
REQ-024 Without FEED_SCHED_PERF_EN: the port and its logic are absent; all other behaviour is identical.

Structure
REQ-025 Package systolic_pkg holds the FSM state enum, the phase typedef, and the SYSTOLIC_SIZE/FIFO_DEPTH defaults.
REQ-026 Sub-module feed_phase_mux holds the phase toggle, read-address mux and valid_a/valid_b delay register.

Verification
REQ-027 N=4, bases A=0/B=16, completed stubs per diagonal -> 7 array_shift pulses, done exactly DRAIN_CYCLES (31) cycles after the 7th.
REQ-028 FEED with fifo_addr_a=5, fifo_addr_b=20 -> fifo_rd_addr alternates 5,20; valid_a follows each 5 by 1 cycle, valid_b follows each 20 by 1 cycle.
REQ-029 completed_a arrives 6 cycles before completed_b -> no valid_a until SHIFT; single array_shift pulse.
REQ-030 start with N=0, then N=17 -> cfg_err pulses each time, busy stays 0.
REQ-031 abort in the 3rd FEED cycle -> one ext_rst_flush cycle, then IDLE, no done.
REQ-032 rst_n low mid-DRAIN -> all outputs 0 asynchronously; a later start with N=2 completes with 3 array_shift pulses.
